// File: rtl/mult_div_unit.sv
// Iterative MIPS32 multiply/divide unit owning the HI/LO registers.
// Optional MDU_EARLY_OUT_EN: zero-operand multiplies and divide-by-zero skip the RUN phase.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dz_q, dz_d;
  logic        zero_q, zero_d;
  logic [31:0] a_raw_q, a_raw_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] acc_q, acc_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        a_neg_s, b_neg_s, skip_s;
  logic [31:0] a_mag_s, b_mag_s;
  logic [32:0] mul_sum_s;
  logic [32:0] div_shift_s;
  logic [33:0] div_diff_s;
  logic [63:0] prod_s;
  logic [31:0] quo_s, rem_s;

  assign a_neg_s = ~op[0] & a[31];
  assign b_neg_s = ~op[0] & b[31];
  assign a_mag_s = a_neg_s ? (32'd0 - a) : a;
  assign b_mag_s = b_neg_s ? (32'd0 - b) : b;

  // acc holds {partial product, remaining multiplier bits} for multiply, dividend/quotient in [31:0] for divide
  assign mul_sum_s   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign div_shift_s = {rem_q[31:0], acc_q[31]};
  assign div_diff_s  = {1'b0, div_shift_s} - {2'b00, opnd_q};

  assign prod_s = neg_res_q ? (64'd0 - acc_q) : acc_q;
  assign quo_s  = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
  assign rem_s  = neg_rem_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];

`ifdef MDU_EARLY_OUT_EN
  assign skip_s = op[1] ? (b == 32'd0) : ((a == 32'd0) || (b == 32'd0));
`else
  assign skip_s = 1'b0;
`endif

  // Next-state, datapath and HI/LO update logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    zero_d    = zero_q;
    a_raw_d   = a_raw_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE: begin
        if (hi_we) begin
          hi_d = wdata;
        end else begin
          hi_d = hi_q;
        end
        if (lo_we) begin
          lo_d = wdata;
        end else begin
          lo_d = lo_q;
        end
        if (start) begin
          is_div_d  = op[1];
          neg_res_d = a_neg_s ^ b_neg_s;
          neg_rem_d = a_neg_s;
          dz_d      = op[1] & (b == 32'd0);
          zero_d    = ~op[1] & ((a == 32'd0) || (b == 32'd0));
          a_raw_d   = a;
          opnd_d    = op[1] ? b_mag_s : a_mag_s;
          acc_d     = op[1] ? {32'd0, a_mag_s} : {32'd0, b_mag_s};
          rem_d     = 33'd0;
          cnt_d     = 5'd0;
          state_d   = skip_s ? S_FIX : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          if (!div_diff_s[33]) begin
            rem_d = div_diff_s[32:0];
            acc_d = {acc_q[63:32], acc_q[30:0], 1'b1};
          end else begin
            rem_d = div_shift_s;
            acc_d = {acc_q[63:32], acc_q[30:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum_s, acc_q[31:1]};
        end
        if (cnt_q == 5'd31) begin
          cnt_d   = 5'd0;
          state_d = S_FIX;
        end else begin
          cnt_d   = cnt_q + 5'd1;
          state_d = S_RUN;
        end
      end
      S_FIX: begin
        if (is_div_q) begin
          if (dz_q) begin
            hi_d = a_raw_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            hi_d = rem_s;
            lo_d = quo_s;
          end
        end else begin
          if (zero_q) begin
            hi_d = 32'd0;
            lo_d = 32'd0;
          end else begin
            hi_d = prod_s[63:32];
            lo_d = prod_s[31:0];
          end
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 5'd0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIX);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      zero_q    <= 1'b0;
      a_raw_q   <= 32'd0;
      opnd_q    <= 32'd0;
      acc_q     <= 64'd0;
      rem_q     <= 33'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      zero_q    <= zero_d;
      a_raw_q   <= a_raw_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
